pacman_life_ctrl: RTL

//  Game-flow sequencer for lives: owns the lives count and sequences start, ready, play, death and game-over phases.

---
 rtl/pacman_game_pkg.sv | 37 +++
 rtl/pacman_life_ctrl_if.sv | 30 +++
 rtl/pacman_life_ctrl_frame_timer.sv | 62 ++++++
 rtl/pacman_life_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pacman_game_pkg.sv
// Shared types, constants and helpers for the Pac-Man life/game-flow sequencer.
package pacman_game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READY     = 3'd1,
        PLAY      = 3'd2,
        DYING     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int LIVES_W     = 3;
    localparam int LIVES_OUT_W = 2;
    localparam int TMR_W       = 8;
    localparam int DFRAME_W    = 4;

    localparam int DEF_START_LIVES       = 3;
    localparam int DEF_READY_FRAMES      = 120;
    localparam int DEF_DEATH_STEPS       = 11;
    localparam int DEF_DEATH_STEP_FRAMES = 8;
    localparam int DEF_GAMEOVER_FRAMES   = 180;
    localparam int DEF_SCORE_W           = 20;
    localparam int DEF_EXTRA_LIFE_SCORE  = 10000;

    localparam logic [LIVES_W-1:0] MAX_TOTAL = 3'd4;

    function automatic logic [LIVES_W-1:0] total_inc_sat(input logic [LIVES_W-1:0] t);
        logic [LIVES_W-1:0] r;
        if (t >= MAX_TOTAL) begin
            r = MAX_TOTAL;
        end else begin
            r = t + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pacman_life_ctrl_if.sv
// Game-flow inputs from the playfield and the outputs consumed by HUD and movement logic.
interface pacman_life_ctrl_if #(
    parameter int SCORE_W = 20
);
    logic               frame_tick;
    logic               start_game;
    logic               pacman_caught;
    logic               level_clear;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic               play_enable;
    logic               show_ready;
    logic               death_anim;
    logic [3:0]         death_frame;
    logic               reset_positions;
    logic               extra_life;
    logic               game_over;

    modport master (
        output frame_tick, start_game, pacman_caught, level_clear, score,
        input  lives, play_enable, show_ready, death_anim, death_frame,
               reset_positions, extra_life, game_over
    );

    modport slave (
        input  frame_tick, start_game, pacman_caught, level_clear, score,
        output lives, play_enable, show_ready, death_anim, death_frame,
               reset_positions, extra_life, game_over
    );
endinterface

// File: rtl/pacman_life_ctrl_frame_timer.sv
// Frame-count down-timer; in death mode it also steps through the death sprite sequence.
module frame_timer
    import pacman_game_pkg::*;
#(
    parameter int DEATH_STEPS       = DEF_DEATH_STEPS,
    parameter int DEATH_STEP_FRAMES = DEF_DEATH_STEP_FRAMES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [TMR_W-1:0]    load_val_i,
    input  logic                tick_i,
    input  logic                death_mode_i,
    output logic                expire_o,
    output logic                death_done_o,
    output logic [DFRAME_W-1:0] death_frame_o
);

    logic [TMR_W-1:0]    cnt_q, cnt_d;
    logic [DFRAME_W-1:0] step_q, step_d;
    logic                expire_s;
    logic                last_step_s;

    assign expire_s      = tick_i && (cnt_q == TMR_W'(1));
    assign last_step_s   = (step_q == DFRAME_W'(DEATH_STEPS - 1));
    assign expire_o      = expire_s;
    assign death_done_o  = expire_s && death_mode_i && last_step_s;
    assign death_frame_o = step_q;

    // Next count: a load always wins; a death step reloads until the last step.
    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        if (load_i) begin
            cnt_d  = load_val_i;
            step_d = {DFRAME_W{1'b0}};
        end else if (expire_s) begin
            if (death_mode_i && !last_step_s) begin
                cnt_d  = TMR_W'(DEATH_STEP_FRAMES);
                step_d = step_q + 4'd1;
            end else begin
                cnt_d = {TMR_W{1'b0}};
            end
        end else if (tick_i && (cnt_q != {TMR_W{1'b0}})) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and step registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {TMR_W{1'b0}};
            step_q <= {DFRAME_W{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/pacman_life_ctrl.sv
// Lives owner and game-phase sequencer: IDLE -> READY -> PLAY -> DYING -> READY/GAME_OVER.
module pacman_life_ctrl
    import pacman_game_pkg::*;
#(
    parameter int START_LIVES       = DEF_START_LIVES,
    parameter int READY_FRAMES      = DEF_READY_FRAMES,
    parameter int DEATH_STEPS       = DEF_DEATH_STEPS,
    parameter int DEATH_STEP_FRAMES = DEF_DEATH_STEP_FRAMES,
    parameter int GAMEOVER_FRAMES   = DEF_GAMEOVER_FRAMES,
    parameter int SCORE_W           = DEF_SCORE_W,
    parameter int EXTRA_LIFE_SCORE  = DEF_EXTRA_LIFE_SCORE
) (
    input  logic               Clk,
    input  logic               Reset_n,
    pacman_life_ctrl_if.slave  bus
);

    state_t                   state_q, state_d;
    logic [LIVES_W-1:0]       total_q, total_d;
    logic                     awarded_q, awarded_d;
    logic [LIVES_OUT_W-1:0]   lives_q, lives_d;
    logic                     play_enable_q, play_enable_d;
    logic                     show_ready_q, show_ready_d;
    logic                     death_anim_q, death_anim_d;
    logic                     reset_pos_q, reset_pos_d;
    logic                     extra_life_q, extra_life_d;
    logic                     game_over_q, game_over_d;

    logic                     tmr_load_s;
    logic [TMR_W-1:0]         tmr_val_s;
    logic                     tmr_expire_s;
    logic                     tmr_death_done_s;
    logic [DFRAME_W-1:0]      tmr_frame_s;
    logic                     bonus_s;
    logic                     died_s;
    logic                     in_game_s;

    frame_timer #(
        .DEATH_STEPS       (DEATH_STEPS),
        .DEATH_STEP_FRAMES (DEATH_STEP_FRAMES)
    ) u_timer (
        .clk           (Clk),
        .rst_n         (Reset_n),
        .load_i        (tmr_load_s),
        .load_val_i    (tmr_val_s),
        .tick_i        (bus.frame_tick),
        .death_mode_i  (state_q == DYING),
        .expire_o      (tmr_expire_s),
        .death_done_o  (tmr_death_done_s),
        .death_frame_o (tmr_frame_s)
    );

    // Next-state, lives bookkeeping and timer loads.
    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        awarded_d    = awarded_q;
        reset_pos_d  = 1'b0;
        extra_life_d = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {TMR_W{1'b0}};
        died_s       = 1'b0;
        bonus_s      = ((state_q == READY) || (state_q == PLAY) || (state_q == DYING)) &&
                       (bus.score >= SCORE_W'(EXTRA_LIFE_SCORE)) && !awarded_q;
        case (state_q)
            IDLE: begin
                if (bus.start_game) begin
                    state_d     = READY;
                    total_d     = LIVES_W'(START_LIVES);
                    awarded_d   = 1'b0;
                    reset_pos_d = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TMR_W'(READY_FRAMES);
                end else begin
                    state_d = IDLE;
                end
            end
            READY: begin
                if (tmr_expire_s) begin
                    state_d = PLAY;
                end else begin
                    state_d = READY;
                end
            end
            PLAY: begin
                if (bus.pacman_caught) begin
                    state_d    = DYING;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TMR_W'(DEATH_STEP_FRAMES);
                end else if (bus.level_clear) begin
                    state_d     = READY;
                    reset_pos_d = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TMR_W'(READY_FRAMES);
                end else begin
                    state_d = PLAY;
                end
            end
            DYING: begin
                died_s = tmr_death_done_s;
            end
            GAME_OVER: begin
                if (tmr_expire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAME_OVER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A bonus landing on the death decrement cancels it, so the game never ends there.
        if (bonus_s) begin
            awarded_d    = 1'b1;
            extra_life_d = 1'b1;
            if (!died_s) begin
                total_d = total_inc_sat(total_q);
            end else begin
                total_d = total_q;
            end
        end else if (died_s) begin
            total_d = total_q - 3'd1;
        end else begin
            total_d = total_d;
        end

        if (died_s) begin
            tmr_load_s = 1'b1;
            if (total_d == {LIVES_W{1'b0}}) begin
                state_d   = GAME_OVER;
                tmr_val_s = TMR_W'(GAMEOVER_FRAMES);
            end else begin
                state_d     = READY;
                reset_pos_d = 1'b1;
                tmr_val_s   = TMR_W'(READY_FRAMES);
            end
        end else begin
            tmr_load_s = tmr_load_s;
        end
    end

    // Phase outputs decoded from the next state so they register with it.
    always_comb begin
        in_game_s     = (state_d == READY) || (state_d == PLAY) || (state_d == DYING);
        lives_d       = in_game_s ? LIVES_OUT_W'(total_d - 3'd1) : {LIVES_OUT_W{1'b0}};
        play_enable_d = (state_d == PLAY);
        show_ready_d  = (state_d == READY);
        death_anim_d  = (state_d == DYING);
        game_over_d   = (state_d == GAME_OVER);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            total_q       <= {LIVES_W{1'b0}};
            awarded_q     <= 1'b0;
            lives_q       <= {LIVES_OUT_W{1'b0}};
            play_enable_q <= 1'b0;
            show_ready_q  <= 1'b0;
            death_anim_q  <= 1'b0;
            reset_pos_q   <= 1'b0;
            extra_life_q  <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            awarded_q     <= awarded_d;
            lives_q       <= lives_d;
            play_enable_q <= play_enable_d;
            show_ready_q  <= show_ready_d;
            death_anim_q  <= death_anim_d;
            reset_pos_q   <= reset_pos_d;
            extra_life_q  <= extra_life_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.lives           = lives_q;
    assign bus.play_enable     = play_enable_q;
    assign bus.show_ready      = show_ready_q;
    assign bus.death_anim      = death_anim_q;
    assign bus.death_frame     = tmr_frame_s;
    assign bus.reset_positions = reset_pos_q;
    assign bus.extra_life      = extra_life_q;
    assign bus.game_over       = game_over_q;

endmodule
